// File: rtl/stream_frame_interface.sv
// rtl/stream_frame_interface.sv - framed command stream parser with core command issue and result FIFO
// Optional feature: define STREAM_FRAME_LEN_CHECK_EN to build the output-length checker driving len_err.
module stream_frame_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OP_WIDTH-1:0]   cmd_op,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  y_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_count,
  output logic                  out_count_valid,
  output logic                  len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(1);

  typedef enum logic [2:0] {HDR, LEN, OP, DATA, ISSUE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] counter;
  logic [OP_WIDTH-1:0]   op_reg;
  logic                  accept;
  logic                  len_accept;
  logic                  issue_fire;

  assign accept     = in_valid && in_ready;
  assign len_accept = accept && (state == LEN);
  assign issue_fire = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (clear) state <= HDR;
    else       state <= state_nxt;
  end

  // Next-state and input handshake; a zero record count is swallowed in HDR
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    case (state)
      HDR:   if (accept && (in_data != '0)) state_nxt = LEN;
      LEN:   if (accept) state_nxt = OP;
      OP:    if (accept) state_nxt = DATA;
      DATA:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        in_ready = 1'b0;
        if (issue_fire) state_nxt = (counter == ONE) ? HDR : OP;
      end
      default: state_nxt = HDR;
    endcase
  end

  // Frame datapath: record counter, expected length, opcode latch and command registers
  always_ff @(posedge clk) begin
    if (clear) begin
      counter         <= '0;
      op_reg          <= '0;
      cmd_op          <= '0;
      cmd_data        <= '0;
      cmd_valid       <= 1'b0;
      out_count       <= '0;
      out_count_valid <= 1'b0;
    end else begin
      out_count_valid <= 1'b0;
      case (state)
        HDR: if (accept) counter <= in_data;
        LEN: if (accept) begin
          out_count       <= in_data;
          out_count_valid <= 1'b1;
        end
        OP: if (accept) op_reg <= in_data[OP_WIDTH-1:0];
        DATA: if (accept) begin
          cmd_data  <= in_data;
          cmd_op    <= op_reg;
          cmd_valid <= 1'b1;
        end
        ISSUE: if (issue_fire) begin
          cmd_valid <= 1'b0;
          counter   <= counter - ONE;
        end
        default: ;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, empty, push, pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign res_ready = !full;
  assign y_valid   = !empty;
  assign push      = res_valid && res_ready;
  assign pop       = y_valid && out_ready;
  // Stale entries stay in memory after clear, so mask the head while empty
  assign data_out  = empty ? '0 : mem[rd_ptr];

  // Result storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef STREAM_FRAME_LEN_CHECK_EN
  logic [DATA_WIDTH-1:0] pop_cnt;
  logic                  len_err_q;

  // Count words popped since the last L and flag over- or under-length frames
  always_ff @(posedge clk) begin
    if (clear) begin
      pop_cnt   <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (len_accept)  pop_cnt <= '0;
      else if (pop)    pop_cnt <= pop_cnt + ONE;
      if ((pop && (pop_cnt == out_count)) || (len_accept && (pop_cnt < out_count)))
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_frame_interface.sv
// tb/tb_stream_frame_interface.sv - directed self-checking bench for stream_frame_interface
module tb_stream_frame_interface;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] data_out;
  logic        y_valid;
  logic        out_ready;
  logic [31:0] out_count;
  logic        out_count_valid;
  logic        len_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t1, t2, pops;
  logic [31:0] exp_word;
  logic        exp_len_err;

  stream_frame_interface #(.DATA_WIDTH(32), .OP_WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .data_out(data_out), .y_valid(y_valid), .out_ready(out_ready),
    .out_count(out_count), .out_count_valid(out_count_valid), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_op"}, 32'(cmd_op), 32'd0);
    check({tag, "_cmd_data"}, cmd_data, 32'd0);
    check({tag, "_res_ready"}, 32'(res_ready), 32'd1);
    check({tag, "_y_valid"}, 32'(y_valid), 32'd0);
    check({tag, "_data_out"}, data_out, 32'd0);
    check({tag, "_out_count"}, out_count, 32'd0);
    check({tag, "_ocv"}, 32'(out_count_valid), 32'd0);
    check({tag, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  initial begin
`ifdef STREAM_FRAME_LEN_CHECK_EN
    exp_len_err = 1'b1;
`else
    exp_len_err = 1'b0;
`endif
    clear = 1'b1; in_data = '0; in_valid = 1'b0; cmd_ready = 1'b0;
    res_data = '0; res_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    clear = 1'b0;
    check_reset_outputs("rst");

    // Single frame N=2, L=1, records (2,0x11), (3,0x22)
    cmd_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'd2; tick();
    check("f1_no_pulse_on_n", 32'(out_count_valid), 32'd0);
    in_data = 32'd1; tick();
    check("f1_ocv", 32'(out_count_valid), 32'd1);
    check("f1_out_count", out_count, 32'd1);
    in_data = 32'd2; tick();
    check("f1_ocv_one_cycle", 32'(out_count_valid), 32'd0);
    in_data = 32'h11; tick();
    t1 = cyc;
    check("f1_c1_valid", 32'(cmd_valid), 32'd1);
    check("f1_c1_op", 32'(cmd_op), 32'd2);
    check("f1_c1_data", cmd_data, 32'h11);
    check("f1_issue_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'd3; tick();
    check("f1_c1_done", 32'(cmd_valid), 32'd0);
    check("f1_op_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 32'h22; tick();
    t2 = cyc;
    check("f1_c2_valid", 32'(cmd_valid), 32'd1);
    check("f1_c2_op", 32'(cmd_op), 32'd3);
    check("f1_c2_data", cmd_data, 32'h22);
    check("f1_issue_gap", 32'(t2 - t1), 32'd3);
    in_valid = 1'b0; tick();
    check("f1_c2_done", 32'(cmd_valid), 32'd0);

    // N=0 header is discarded; following N=1 frame with core stalled 5 cycles
    cmd_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'd0; tick();
    check("n0_ready", 32'(in_ready), 32'd1);
    in_data = 32'd1; tick();
    check("n0_next_is_n", 32'(out_count_valid), 32'd0);
    in_data = 32'd5; tick();
    check("f2_ocv", 32'(out_count_valid), 32'd1);
    check("f2_out_count", out_count, 32'd5);
    in_data = 32'd7; tick();
    in_data = 32'hABCD; tick();
    in_data = 32'h99;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_op", 32'(cmd_op), 32'd7);
      check("stall_data", cmd_data, 32'hABCD);
      tick();
    end
    in_valid = 1'b0; cmd_ready = 1'b1; tick();
    check("stall_done_valid", 32'(cmd_valid), 32'd0);
    check("stall_done_in_ready", 32'(in_ready), 32'd1);
    cmd_ready = 1'b0;

    // Fill FIFO with 9 attempted results while the consumer is stalled
    res_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      res_data = 32'h100 + 32'(i); tick();
      if (i == 0) begin
        check("fifo_first_valid", 32'(y_valid), 32'd1);
        check("fifo_first_head", data_out, 32'h100);
      end
      if (i == 6) check("fifo_7_ready", 32'(res_ready), 32'd1);
      if (i == 7) check("fifo_8_full", 32'(res_ready), 32'd0);
    end
    res_data = 32'h108; tick();
    check("fifo_full_hold", 32'(res_ready), 32'd0);
    check("fifo_full_head", data_out, 32'h100);
    out_ready = 1'b1; tick();
    check("fifo_pop_ready", 32'(res_ready), 32'd1);
    check("fifo_pop_head", data_out, 32'h101);
    tick();
    check("fifo_pushpop_ready", 32'(res_ready), 32'd1);
    res_valid = 1'b0;
    exp_word = 32'h102; pops = 0;
    for (int k = 0; k < 20 && y_valid; k++) begin
      check("fifo_order", data_out, exp_word);
      exp_word = exp_word + 1; pops++;
      tick();
    end
    check("fifo_occupancy7", 32'(pops), 32'd7);
    check("fifo_drained", 32'(y_valid), 32'd0);
    out_ready = 1'b0;

    // Clear mid-record in DATA with 3 results buffered
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_data = 32'h200 + 32'(i); tick();
    end
    res_valid = 1'b0;
    check("pre_clr_head", data_out, 32'h200);
    in_valid = 1'b1;
    in_data = 32'd1; tick();
    in_data = 32'd3; tick();
    in_data = 32'd5; tick();
    in_data = 32'h55; clear = 1'b1; tick();
    clear = 1'b0; in_valid = 1'b0;
    check_reset_outputs("clr");
    tick();
    check("clr_no_cmd", 32'(cmd_valid), 32'd0);
    check("clr_empty", 32'(y_valid), 32'd0);

    // Length check: L=2 then pop 3 words
    in_valid = 1'b1;
    in_data = 32'd1; tick();
    in_data = 32'd2; tick();
    check("lc_ocv", 32'(out_count_valid), 32'd1);
    check("lc_out_count", out_count, 32'd2);
    in_data = 32'd4; tick();
    in_data = 32'h44; tick();
    in_valid = 1'b0;
    check("lc_cmd_data", cmd_data, 32'h44);
    cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0;
    check("lc_cmd_done", 32'(cmd_valid), 32'd0);
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_data = 32'h300 + 32'(i); tick();
    end
    res_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("lc_two_pops", 32'(len_err), 32'd0);
    check("lc_head3", data_out, 32'h302);
    tick();
    check("lc_third_pop", 32'(len_err), 32'(exp_len_err));
    tick(); tick();
    check("lc_sticky", 32'(len_err), 32'(exp_len_err));
    out_ready = 1'b0;
    clear = 1'b1; tick();
    clear = 1'b0;
    check("lc_cleared", 32'(len_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_frame_interface.md
# stream_frame_interface

Parametrised successor to the single-word host interface. It accepts framed command streams on a valid/ready input bus and parses each frame's header and operation records. Each record is issued to the compute core over a registered command handshake. Core results are buffered in an output FIFO and returned on a valid/ready output bus. It sits between the host/testbench bus and the controller core.

## Interface
- `DATA_WIDTH`, 32: width of input, output and command data words.
- `OP_WIDTH`, 4: number of opcode bits taken from bits [OP_WIDTH-1:0] of an operation word.
- `DEPTH`, 8: output FIFO depth, in entries; must be a power of two, ≥2.
- `clk` in 1: global clock; all logic on its rising edge.
- `clear` in 1: synchronous, active-high reset.
- `in_data` in DATA_WIDTH: input word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `cmd_op` out OP_WIDTH: opcode of the issued record.
- `cmd_data` out DATA_WIDTH: data word of the issued record.
- `cmd_valid` out 1: command is pending to the core.
- `cmd_ready` in 1: the core takes the command.
- `res_data` in DATA_WIDTH: result word from the core.
- `res_valid` in 1: result is valid.
- `res_ready` out 1: the FIFO can take the result.
- `data_out` out DATA_WIDTH: FIFO head word.
- `y_valid` out 1: `data_out` is valid.
- `out_ready` in 1: the consumer takes `data_out`.
- `out_count` out DATA_WIDTH: expected output length of the current frame.
- `out_count_valid` out 1: one-cycle pulse when `out_count` is updated.
- `len_err` out 1: sticky output-length mismatch flag (see Configuration).

## Operation
- Frame format:
  - word 0: N, the record count.
  - word 1: L, the expected output length.
  - then N records, each an op word followed by a data word.
- An input word is accepted when `in_valid && in_ready`.
- `in_ready` is high in states HDR, LEN, OP and DATA, and low in ISSUE.
- FSM states: HDR, LEN, OP, DATA, ISSUE.
  - HDR: on accept, load `counter` ← N.
    - If N == 0, the word is discarded and the FSM stays in HDR; no LEN word is expected.
    - Otherwise go to LEN.
  - LEN: on accept, `out_count` ← L and pulse `out_count_valid` the next cycle; go to OP.
  - OP: on accept, latch `op_reg` ← `in_data[OP_WIDTH-1:0]`; go to DATA.
  - DATA: on accept, set `cmd_data` ← `in_data`, `cmd_op` ← `op_reg`, `cmd_valid` ← 1; go to ISSUE.
  - ISSUE: hold `cmd_*` stable until `cmd_valid && cmd_ready`. In that cycle, clear `cmd_valid`, decrement `counter`, then:
    - If `counter` was 1, go to HDR.
    - Otherwise go to OP.
- Counter width is DATA_WIDTH and it never wraps: N == 0 is filtered in HDR, and the counter only decrements from nonzero values.
- The core path and the output path are decoupled. Results may arrive at any time, including while in HDR.
- FIFO:
  - `res_ready` = !full.
  - Push on `res_valid && res_ready`.
  - `y_valid` = !empty; `data_out` = head entry.
  - Pop on `y_valid && out_ready`.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged.
- No push is possible when full, even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is held in a log2(DEPTH)+1 bit count.
- On `clear`, mid-frame or otherwise:
  - FSM → HDR, counter → 0, FIFO emptied, any pending command dropped.
  - Reset values: `in_ready`=1 (HDR), `cmd_valid`=0, `cmd_op`=0, `cmd_data`=0, `res_ready`=1, `y_valid`=0, `data_out`=0, `out_count`=0, `out_count_valid`=0, `len_err`=0.

## Timing
- Each outer state (HDR, LEN, OP, DATA) accepts one word per cycle.
- Per record, minimum 3 cycles: OP, DATA, then ISSUE with `cmd_ready` already high.
- `cmd_valid` rises the cycle after the data word is accepted.
- `out_count_valid` pulses exactly one cycle, the cycle after L is accepted.
- Result to output latency: a result pushed at edge t is visible on `data_out`/`y_valid` after edge t. Empty-FIFO latency is 1 cycle.
- `res_ready` drops in the same cycle that occupancy reaches DEPTH.

## Configuration
- `STREAM_FRAME_LEN_CHECK_EN` defined:
  - A popped-word counter resets to 0 when L is accepted.
  - `len_err` sets and stays set until `clear` when either:
    - a pop occurs while the counter already equals L, or
    - a new LEN word is accepted while the counter < L.
- `STREAM_FRAME_LEN_CHECK_EN` not defined: `len_err` is tied to 0 and no counter logic is built.

## Test plan
- Single frame N=2, L=1, records (op 2, 0x11), (op 3, 0x22), `cmd_ready`=1 → `out_count`=1 with one pulse; commands (2,0x11), (3,0x22) issued 3 cycles apart; FSM returns to HDR.
- Header N=0 followed by N=1 frame → first word discarded; next word is treated as N, not L.
- `cmd_ready` held low 5 cycles in ISSUE → `in_ready`=0 and `cmd_*` stable throughout; issue completes on the first cycle `cmd_ready`=1.
- DEPTH=8, 9 results with `out_ready`=0 → `res_ready` goes low after 8 pushes. Then `out_ready`=1 → words pop in order; simultaneous push and pop keeps occupancy at 7.
- `clear` asserted mid-record (in DATA) with FIFO holding 3 entries → next cycle: HDR, `y_valid`=0, `cmd_valid`=0, all outputs at reset values.
- With the macro defined: L=2, pop 3 words → `len_err`=1, and it stays 1 until `clear`.
